lif_neuron_multisyn: RTL and testbench
======================================

Name: lif_neuron_multisyn

Overview:
- Parametrised fixed-point leaky integrate-and-fire neuron with NUM_SYN synaptic inputs.
- Each time step is accepted through a valid/ready handshake. Weights of active synapses are accumulated serially, one synapse per cycle, then one update cycle applies leak, threshold, fire and refractory.
- Adds selectable reset mode, symmetric leak toward zero, and saturating arithmetic.
- Sits between the spike-routing layer and the next-layer spike bus; one instance per neuron.

Parameters:
- W, 16, signed two's-complement data width of potential, weights and threshold.
- NUM_SYN, 4, number of synaptic inputs (≥1).
- TR_W, 8, width of refractory counter and tref.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- step_valid  in  1  new time step offered
- step_ready  out  1  neuron idle, can accept step
- spike_vec  in  NUM_SYN  input spikes; bit k = synapse k
- weight_flat  in  NUM_SYN*W  signed weights; weight k at bits [k*W +: W]
- threshold  in  W  signed firing threshold
- leak_value  in  W  unsigned leak magnitude; values > 2^(W-1)-1 clamp to 2^(W-1)-1
- tref  in  TR_W  refractory length in steps
- reset_mode  in  1  0 = reset to zero on fire, 1 = subtract threshold
- memb_potential_out  out  W  signed membrane potential after last update
- spike_out  out  1  fire flag, valid with step_done
- tr  out  TR_W  remaining refractory steps
- step_done  out  1  one-cycle pulse: step update complete

Behaviour:
- Reset, asynchronous and any time including mid-step:
  - FSM to IDLE.
  - V, accumulator, synapse index, memb_potential_out, spike_out, tr, step_done all 0.
  - step_ready = 1.
- FSM states IDLE → ACCUM → UPDATE → IDLE.
- IDLE:
  - step_ready = 1.
  - On step_valid & step_ready: latch spike_vec, weight_flat, threshold, leak_value, tref and reset_mode.
  - Set acc = V and index = 0; go to ACCUM.
- ACCUM:
  - step_ready = 0; step_valid is ignored.
  - Exactly NUM_SYN cycles. Each cycle: acc = sat(acc + (spike[k] ? w[k] : 0)); k increments.
  - After k = NUM_SYN-1, go to UPDATE.
- UPDATE (one cycle), evaluated in this priority order:
  - tr > 0: tr ← tr-1, V ← 0, spike_out ← 0. The accumulated input is discarded.
  - Else compute L from acc with leak toward zero:
    - acc > leak → L = acc − leak
    - acc < −leak → L = acc + leak
    - otherwise L = 0
  - L ≥ threshold (signed compare): spike_out ← 1, tr ← tref, V ← (reset_mode ? sat(L − threshold) : 0).
  - Otherwise: spike_out ← 0, V ← L.
  - memb_potential_out ← new V.
  - step_done ← 1 for the next cycle only; FSM returns to IDLE.
- Latency:
  - Accept edge at cycle 0; step_done high in cycle NUM_SYN+1.
  - spike_out, memb_potential_out and tr are valid from that cycle.
  - spike_out clears with the next update (or reset) and holds until then.
- Throughput: one step per NUM_SYN+2 cycles. A new accept is possible in the cycle step_done is high.
- sat(): computed in W+1 bits, clamped to [−2^(W−1), 2^(W−1)−1]; no wrap-around.
- threshold ≤ 0: neuron fires on every non-refractory step whose L ≥ threshold; no special casing.
- tref = 0: no refractory period; integration resumes on the next step.
- Inputs changing after accept have no effect on the step in flight.

Test Plan:
- Reset mid-ACCUM (W=16, NUM_SYN=4) → outputs immediately 0, step_ready=1; next accepted step starts from V=0.
- Integrate, no fire: V=0; spike_vec=4'b0101; w0=100, w1=50, w2=30, w3=7; leak=10; thr=1000 → step_done at cycle 5 after accept, memb=120, spike_out=0.
- Fire, reset_mode=0, tref=2: repeat a step with w0=600 only, spike_vec=4'b0001, leak=10, thr=1000.
  - Step 1 → memb 590.
  - Step 2 → L=1180: spike_out=1, memb=0, tr=2.
  - Steps 3 and 4 → spike_out=0, memb=0, tr=1 then 0; inputs ignored.
  - Step 5 → memb=590.
- Subtract mode: same stimulus with reset_mode=1 → step 2 gives spike_out=1, memb=180.
- Saturation: all four weights −32768, all spikes, leak=0 → memb=−32768, no fire. All four weights 32767, thr=32767 → acc clamps to 32767, spike_out=1.
- Leak toward zero and handshake:
  - V=−25, no spikes, leak=10 → memb=−15. V=5, leak=10 → memb=0.
  - step_valid held high during ACCUM → no second accept until IDLE, and step_done pulses once per accepted step.

Source files
------------

// File: rtl/lif_neuron_multisyn.sv
// rtl/lif_neuron_multisyn.sv - leaky integrate-and-fire neuron with serial multi-synapse accumulation
module lif_neuron_multisyn #(
    parameter int W       = 16,
    parameter int NUM_SYN = 4,
    parameter int TR_W    = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   step_valid,
    output logic                   step_ready,
    input  logic [NUM_SYN-1:0]     spike_vec,
    input  logic [NUM_SYN*W-1:0]   weight_flat,
    input  logic [W-1:0]           threshold,
    input  logic [W-1:0]           leak_value,
    input  logic [TR_W-1:0]        tref,
    input  logic                   reset_mode,
    output logic [W-1:0]           memb_potential_out,
    output logic                   spike_out,
    output logic [TR_W-1:0]        tr,
    output logic                   step_done
);

    localparam int IDX_W = (NUM_SYN > 1) ? $clog2(NUM_SYN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SYN - 1);

    // Saturation bounds expressed in the W+1 bit working width
    localparam logic signed [W:0] SMAX = {2'b00, {(W-1){1'b1}}};
    localparam logic signed [W:0] SMIN = {2'b11, {(W-1){1'b0}}};
    localparam logic [W-1:0] LEAK_MAX  = {1'b0, {(W-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_UPDATE
    } state_t;

    state_t                  state;
    logic signed [W-1:0]     acc;
    logic signed [W-1:0]     v;
    logic [IDX_W-1:0]        idx;
    logic [NUM_SYN-1:0]      spike_r;
    logic [NUM_SYN*W-1:0]    weight_r;
    logic [W-1:0]            thr_r;
    logic [W-1:0]            leak_r;
    logic [TR_W-1:0]         tref_r;
    logic                    mode_r;

    logic [W-1:0]            cur_w;
    logic                    cur_s;
    logic signed [W:0]       acc_x;
    logic signed [W:0]       w_x;
    logic signed [W:0]       sum_x;
    logic signed [W:0]       leak_x;
    logic signed [W:0]       l_x;
    logic signed [W:0]       thr_x;
    logic signed [W:0]       diff_x;
    logic                    fire;

    function automatic logic signed [W-1:0] sat(input logic signed [W:0] x);
        if (x > SMAX) begin
            return SMAX[W-1:0];
        end else if (x < SMIN) begin
            return SMIN[W-1:0];
        end else begin
            return x[W-1:0];
        end
    endfunction

    // Select the weight and spike bit of the synapse currently being integrated
    always_comb begin
        cur_w = '0;
        cur_s = 1'b0;
        for (int k = 0; k < NUM_SYN; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_w = weight_r[k*W +: W];
                cur_s = spike_r[k];
            end
        end
    end

    assign acc_x  = {acc[W-1], acc};
    assign w_x    = cur_s ? {cur_w[W-1], cur_w} : '0;
    assign sum_x  = acc_x + w_x;
    assign leak_x = {1'b0, leak_r};
    assign thr_x  = {thr_r[W-1], thr_r};

    // Symmetric leak pulls the accumulated potential toward zero without crossing it
    always_comb begin
        l_x = '0;
        if (acc_x > leak_x) begin
            l_x = acc_x - leak_x;
        end else if (acc_x < -leak_x) begin
            l_x = acc_x + leak_x;
        end
    end

    assign diff_x = l_x - thr_x;
    assign fire   = (l_x >= thr_x);

    assign memb_potential_out = v;

    // Step FSM: accept, serial synapse accumulation, then one leak/fire/refractory update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            acc        <= '0;
            v          <= '0;
            idx        <= '0;
            spike_out  <= 1'b0;
            tr         <= '0;
            step_done  <= 1'b0;
            step_ready <= 1'b1;
            spike_r    <= '0;
            weight_r   <= '0;
            thr_r      <= '0;
            leak_r     <= '0;
            tref_r     <= '0;
            mode_r     <= 1'b0;
        end else begin
            step_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (step_valid) begin
                        spike_r    <= spike_vec;
                        weight_r   <= weight_flat;
                        thr_r      <= threshold;
                        leak_r     <= (leak_value > LEAK_MAX) ? LEAK_MAX : leak_value;
                        tref_r     <= tref;
                        mode_r     <= reset_mode;
                        acc        <= v;
                        idx        <= '0;
                        step_ready <= 1'b0;
                        state      <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    acc <= sat(sum_x);
                    idx <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    if (tr != '0) begin
                        // Refractory: input of this step is thrown away
                        tr        <= tr - TR_W'(1);
                        v         <= '0;
                        spike_out <= 1'b0;
                    end else if (fire) begin
                        spike_out <= 1'b1;
                        tr        <= tref_r;
                        v         <= mode_r ? sat(diff_x) : '0;
                    end else begin
                        spike_out <= 1'b0;
                        v         <= l_x[W-1:0];
                    end
                    step_done  <= 1'b1;
                    step_ready <= 1'b1;
                    state      <= S_IDLE;
                end
                default: begin
                    step_ready <= 1'b1;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lif_neuron_multisyn.sv
// tb/tb_lif_neuron_multisyn.sv - randomized self-checking bench for lif_neuron_multisyn
module tb_lif_neuron_multisyn;

    localparam int W       = 16;
    localparam int NUM_SYN = 4;
    localparam int TR_W    = 8;
    localparam int VMAX    = (1 << (W-1)) - 1;
    localparam int VMIN    = -(1 << (W-1));

    logic                 clk;
    logic                 reset_n;
    logic                 step_valid;
    logic                 step_ready;
    logic [NUM_SYN-1:0]   spike_vec;
    logic [NUM_SYN*W-1:0] weight_flat;
    logic [W-1:0]         threshold;
    logic [W-1:0]         leak_value;
    logic [TR_W-1:0]      tref;
    logic                 reset_mode;
    logic [W-1:0]         memb_potential_out;
    logic                 spike_out;
    logic [TR_W-1:0]      tr;
    logic                 step_done;

    int errors;
    int checks;

    // Stimulus for the next step
    int s_spk;
    int s_w[NUM_SYN];
    int s_thr;
    int s_leak;
    int s_tref;
    int s_mode;

    // Reference neuron state
    int m_v;
    int m_tr;
    int m_spk;

    lif_neuron_multisyn #(.W(W), .NUM_SYN(NUM_SYN), .TR_W(TR_W)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .step_valid        (step_valid),
        .step_ready        (step_ready),
        .spike_vec         (spike_vec),
        .weight_flat       (weight_flat),
        .threshold         (threshold),
        .leak_value        (leak_value),
        .tref              (tref),
        .reset_mode        (reset_mode),
        .memb_potential_out(memb_potential_out),
        .spike_out         (spike_out),
        .tr                (tr),
        .step_done         (step_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clamp(input int x);
        if (x > VMAX) return VMAX;
        if (x < VMIN) return VMIN;
        return x;
    endfunction

    // Neuron behaviour as plain integer arithmetic
    task automatic model_step();
        int acc;
        int lk;
        int l;
        acc = m_v;
        for (int k = 0; k < NUM_SYN; k++) begin
            if (s_spk[k]) acc = clamp(acc + s_w[k]);
        end
        if (m_tr > 0) begin
            m_tr  = m_tr - 1;
            m_v   = 0;
            m_spk = 0;
        end else begin
            lk = (s_leak > VMAX) ? VMAX : s_leak;
            if (acc > lk)       l = acc - lk;
            else if (acc < -lk) l = acc + lk;
            else                l = 0;
            if (l >= s_thr) begin
                m_spk = 1;
                m_tr  = s_tref;
                m_v   = (s_mode != 0) ? clamp(l - s_thr) : 0;
            end else begin
                m_spk = 0;
                m_v   = l;
            end
        end
    endtask

    task automatic drive_stim();
        spike_vec = NUM_SYN'(s_spk);
        for (int k = 0; k < NUM_SYN; k++) weight_flat[k*W +: W] = W'(s_w[k]);
        threshold  = W'(s_thr);
        leak_value = W'(s_leak);
        tref       = TR_W'(s_tref);
        reset_mode = s_mode[0];
    endtask

    task automatic scramble_inputs();
        spike_vec = NUM_SYN'($urandom);
        for (int k = 0; k < NUM_SYN; k++) weight_flat[k*W +: W] = W'($urandom);
        threshold  = W'($urandom);
        leak_value = W'($urandom);
        tref       = TR_W'($urandom);
        reset_mode = 1'($urandom);
    endtask

    task automatic model_reset();
        m_v   = 0;
        m_tr  = 0;
        m_spk = 0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    // Offers one step, tracks latency, then compares outputs to the model
    task automatic do_step(input string tag);
        int n;
        n = 0;
        while (!step_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!step_ready) check({tag, "_ready_timeout"}, 0, 1);
        drive_stim();
        step_valid = 1'b1;
        @(posedge clk);
        #1;
        step_valid = 1'b0;
        model_step();
        scramble_inputs();
        check({tag, "_busy"}, int'(step_ready), 0);
        n = 0;
        while (n < 50) begin
            @(posedge clk);
            #1;
            n++;
            if (step_done) break;
        end
        check({tag, "_latency"}, n, NUM_SYN + 1);
        check({tag, "_memb"}, int'($signed(memb_potential_out)), m_v);
        check({tag, "_spike"}, int'(spike_out), m_spk);
        check({tag, "_tr"}, int'(tr), m_tr);
    endtask

    task automatic set_stim(input int spk, input int w0, input int w1, input int w2, input int w3,
                            input int thr, input int lk, input int trf, input int md);
        s_spk = spk;
        s_w[0] = w0; s_w[1] = w1; s_w[2] = w2; s_w[3] = w3;
        s_thr = thr; s_leak = lk; s_tref = trf; s_mode = md;
    endtask

    int exp_memb[5];
    int exp_spk[5];
    int exp_tr[5];
    int n_done;
    int n_ready;

    initial begin
        errors      = 0;
        checks      = 0;
        reset_n     = 1'b0;
        step_valid  = 1'b0;
        spike_vec   = '0;
        weight_flat = '0;
        threshold   = '0;
        leak_value  = '0;
        tref        = '0;
        reset_mode  = 1'b0;
        model_reset();
        set_stim(0, 0, 0, 0, 0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("rst_memb", int'(memb_potential_out), 0);
        check("rst_spike", int'(spike_out), 0);
        check("rst_tr", int'(tr), 0);
        check("rst_done", int'(step_done), 0);
        check("rst_ready", int'(step_ready), 1);
        reset_n = 1'b1;

        // Integrate without firing
        set_stim(4'b0101, 100, 50, 30, 7, 1000, 10, 0, 0);
        do_step("integ");
        check("integ_const", int'($signed(memb_potential_out)), 120);

        // Reset in the middle of accumulation
        drive_stim();
        step_valid = 1'b1;
        @(posedge clk);
        #1;
        step_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
        #1;
        check("midrst_memb", int'(memb_potential_out), 0);
        check("midrst_ready", int'(step_ready), 1);
        check("midrst_tr", int'(tr), 0);
        check("midrst_spike", int'(spike_out), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        do_step("post_rst");
        check("post_rst_const", int'($signed(memb_potential_out)), 120);

        // Fire with reset-to-zero and a two-step refractory period
        apply_reset();
        exp_memb = '{590, 0, 0, 0, 590};
        exp_spk  = '{0, 1, 0, 0, 0};
        exp_tr   = '{0, 2, 1, 0, 0};
        set_stim(4'b0001, 600, 0, 0, 0, 1000, 10, 2, 0);
        for (int i = 0; i < 5; i++) begin
            do_step("fire0");
            check("fire0_memb_c", int'($signed(memb_potential_out)), exp_memb[i]);
            check("fire0_spk_c", int'(spike_out), exp_spk[i]);
            check("fire0_tr_c", int'(tr), exp_tr[i]);
        end

        // Subtract-threshold reset mode
        apply_reset();
        set_stim(4'b0001, 600, 0, 0, 0, 1000, 10, 2, 1);
        do_step("sub1");
        do_step("sub2");
        check("sub_memb_c", int'($signed(memb_potential_out)), 180);
        check("sub_spk_c", int'(spike_out), 1);

        // Negative and positive saturation
        apply_reset();
        set_stim(4'b1111, -32768, -32768, -32768, -32768, 1000, 0, 0, 0);
        do_step("satneg");
        check("satneg_c", int'($signed(memb_potential_out)), -32768);
        apply_reset();
        set_stim(4'b1111, 32767, 32767, 32767, 32767, 32767, 0, 0, 1);
        do_step("satpos");
        check("satpos_spk_c", int'(spike_out), 1);

        // Leak toward zero from both sides
        apply_reset();
        set_stim(4'b0001, -25, 0, 0, 0, 1000, 0, 0, 0);
        do_step("lk_neg_a");
        set_stim(4'b0000, 0, 0, 0, 0, 1000, 10, 0, 0);
        do_step("lk_neg_b");
        check("lk_neg_c", int'($signed(memb_potential_out)), -15);
        apply_reset();
        set_stim(4'b0001, 5, 0, 0, 0, 1000, 0, 0, 0);
        do_step("lk_pos_a");
        set_stim(4'b0000, 0, 0, 0, 0, 1000, 10, 0, 0);
        do_step("lk_pos_b");
        check("lk_pos_c", int'($signed(memb_potential_out)), 0);

        // step_valid held high across two back-to-back steps
        apply_reset();
        set_stim(4'b0001, 100, 0, 0, 0, 1000, 0, 0, 0);
        drive_stim();
        step_valid = 1'b1;
        n_done  = 0;
        n_ready = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (i >= 1) begin
                if (step_done)  n_done++;
                if (step_ready) n_ready++;
            end
            if (i == 11) step_valid = 1'b0;
        end
        model_step();
        model_step();
        check("hs_done_count", n_done, 2);
        check("hs_ready_count", n_ready, 2);
        check("hs_memb", int'($signed(memb_potential_out)), m_v);
        check("hs_memb_c", int'($signed(memb_potential_out)), 200);

        // Randomized steps against the model
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            s_spk = int'($urandom_range(0, 15));
            for (int k = 0; k < NUM_SYN; k++) begin
                if ($urandom_range(0, 9) == 0) s_w[k] = int'($urandom_range(0, 65535)) - 32768;
                else                           s_w[k] = int'($urandom_range(0, 900)) - 300;
            end
            s_thr  = int'($urandom_range(0, 1500)) - 200;
            s_leak = ($urandom_range(0, 19) == 0) ? int'($urandom_range(32767, 65535))
                                                  : int'($urandom_range(0, 60));
            s_tref = int'($urandom_range(0, 3));
            s_mode = int'($urandom_range(0, 1));
            do_step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
